// File: rtl/ascon_perm_unrolled.sv
// ASCON permutation engine: UNROLL full rounds per clock, per-transaction round count.
// Optional macro ASCON_PERM_ERR_EN adds err_out and rejects rounds_in > 12 instead of clamping.
`timescale 1ns/1ps
module ascon_perm_unrolled #(
    parameter int UNROLL     = 1,
    parameter int MAX_ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [319:0] state_in,
    input  logic [3:0]   rounds_in,
    input  logic         valid_in,
    output logic         ready_out,
    output logic [319:0] state_out,
    output logic         valid_out,
    input  logic         ready_in,
    output logic         busy
`ifdef ASCON_PERM_ERR_EN
    ,
    output logic         err_out
`endif
);

    // Handshake: a word moves only on a clock edge where valid and ready are both high;
    // valid/data are held stable by the source until that edge.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       st_q, st_d;
    logic [319:0] x_q, x_d;
    logic [319:0] out_q, out_d;
    logic [3:0]   rem_q, rem_d;
    logic [3:0]   idx_q, idx_d;
    logic         vout_q, vout_d;
    logic [3:0]   step;
    logic [3:0]   nr_load;
    logic         nr_over;
    logic [319:0] stage [0:UNROLL];

    function automatic logic [63:0] rotr(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        x0 = s[319:256];
        x1 = s[255:192];
        x2 = s[191:128];
        x3 = s[127:64];
        x4 = s[63:0];
        x2[7:0] = x2[7:0] ^ {4'hF - i, i};
        // Bit-sliced 5-bit sbox applied to all 64 columns at once
        x0 ^= x4;
        x4 ^= x3;
        x2 ^= x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 ^= t1;
        x1 ^= t2;
        x2 ^= t3;
        x3 ^= t4;
        x4 ^= t0;
        x1 ^= x0;
        x0 ^= x4;
        x3 ^= x2;
        x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    // Stages beyond the remaining round count pass the state through unchanged
    assign stage[0] = x_q;
    for (genvar k = 0; k < UNROLL; k++) begin : g_stage
        assign stage[k+1] = (4'(k) < rem_q) ? ascon_round(stage[k], idx_q + 4'(k)) : stage[k];
    end

    assign step    = (rem_q < 4'(UNROLL)) ? rem_q : 4'(UNROLL);
    assign nr_over = rounds_in > 4'(MAX_ROUNDS);
`ifdef ASCON_PERM_ERR_EN
    assign nr_load = nr_over ? 4'd0 : rounds_in;
`else
    assign nr_load = nr_over ? 4'(MAX_ROUNDS) : rounds_in;
`endif

    always_comb begin
        st_d   = st_q;
        x_d    = x_q;
        out_d  = out_q;
        rem_d  = rem_q;
        idx_d  = idx_q;
        vout_d = vout_q;
        case (st_q)
            IDLE: begin
                if (valid_in) begin
                    x_d   = state_in;
                    rem_d = nr_load;
                    idx_d = 4'(MAX_ROUNDS) - nr_load;
                    st_d  = RUN;
                end
            end
            RUN: begin
                x_d   = stage[UNROLL];
                rem_d = rem_q - step;
                idx_d = idx_q + step;
                if (rem_q == step) begin
                    out_d  = stage[UNROLL];
                    vout_d = 1'b1;
                    st_d   = DONE;
                end
            end
            DONE: begin
                if (ready_in) begin
                    vout_d = 1'b0;
                    st_d   = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st_q   <= IDLE;
            x_q    <= '0;
            out_q  <= '0;
            rem_q  <= '0;
            idx_q  <= '0;
            vout_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            x_q    <= x_d;
            out_q  <= out_d;
            rem_q  <= rem_d;
            idx_q  <= idx_d;
            vout_q <= vout_d;
        end
    end

`ifdef ASCON_PERM_ERR_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (st_q == IDLE && valid_in) begin
            err_q <= nr_over;
        end
    end

    assign err_out = err_q & vout_q;
`endif

    assign ready_out = (st_q == IDLE);
    assign busy      = (st_q != IDLE);
    assign state_out = out_q;
    assign valid_out = vout_q;

endmodule

// File: tb/tb_ascon_perm_unrolled.sv
// Scoreboard bench for ascon_perm_unrolled: UNROLL=1 and UNROLL=4 instances side by side.
// Honours ASCON_PERM_ERR_EN when the design is built with it.
`timescale 1ns/1ps
module tb_ascon_perm_unrolled;

    localparam int W = 353;   // {err, expected rise cycle[31:0], state[319:0]}
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};
    // p^1 of the all-zero state, derived by hand (constant 0x4B, one sbox layer, pl)
    localparam logic [319:0] HAND_P1 = {64'h000964B00000004B, 64'h0000000096000213,
                                        64'h53FFFFFFFFFFFF90, 64'h12E580000000004B, 64'h0};

    logic         clk;
    logic         rst;
    logic [319:0] s_in  [2];
    logic [3:0]   r_in  [2];
    logic         v_in  [2];
    logic         r_out [2];
    logic [319:0] s_out [2];
    logic         v_out [2];
    logic         rdy   [2];
    logic         bsy   [2];
    logic         err_o [2];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];
    logic         prev_v  [2];
    logic         prev_hs [2];
    logic [319:0] prev_s  [2];
    int           rise    [2];

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    ascon_perm_unrolled #(.UNROLL(1)) u1 (
        .clk(clk), .rst(rst), .state_in(s_in[0]), .rounds_in(r_in[0]), .valid_in(v_in[0]),
        .ready_out(r_out[0]), .state_out(s_out[0]), .valid_out(v_out[0]), .ready_in(rdy[0]),
        .busy(bsy[0])
`ifdef ASCON_PERM_ERR_EN
        , .err_out(err_o[0])
`endif
    );

    ascon_perm_unrolled #(.UNROLL(4)) u4 (
        .clk(clk), .rst(rst), .state_in(s_in[1]), .rounds_in(r_in[1]), .valid_in(v_in[1]),
        .ready_out(r_out[1]), .state_out(s_out[1]), .valid_out(v_out[1]), .ready_in(rdy[1]),
        .busy(bsy[1])
`ifdef ASCON_PERM_ERR_EN
        , .err_out(err_o[1])
`endif
    );

`ifndef ASCON_PERM_ERR_EN
    assign err_o[0] = 1'b0;
    assign err_o[1] = 1'b0;
`endif

    // ---------------- reference model ----------------
    function automatic logic [319:0] model(input logic [319:0] s, input int n);
        logic [63:0]  x [5];
        logic [63:0]  y [5];
        logic [127:0] dd;
        logic [4:0]   v;
        logic [4:0]   o;
        logic [7:0]   c;
        for (int w = 0; w < 5; w++) x[w] = s[319-64*w -: 64];
        for (int r = 12 - n; r < 12; r++) begin
            c = 8'((15 - r) * 16 + r);
            x[2][7:0] = x[2][7:0] ^ c;
            for (int b = 0; b < 64; b++) begin
                v = {x[0][b], x[1][b], x[2][b], x[3][b], x[4][b]};
                o = SBOX[v];
                for (int w = 0; w < 5; w++) y[w][b] = o[4-w];
            end
            for (int w = 0; w < 5; w++) begin
                dd = {y[w], y[w]};
                x[w] = y[w] ^ dd[ROT_A[w] +: 64] ^ dd[ROT_B[w] +: 64];
            end
        end
        return {x[0], x[1], x[2], x[3], x[4]};
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] s;
        for (int i = 0; i < 10; i++) s[32*i +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input bit ok, input string name, input logic [319:0] act,
                       input logic [319:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic issue(input int d, input logic [319:0] s, input logic [3:0] nr,
                         input logic [319:0] es, input bit ee, input int lat, input int hold);
        int guard = 0;
        while (!r_out[d] && guard < 300) begin
            @(posedge clk); #1;
            guard++;
        end
        if (!r_out[d]) begin
            chk(1'b0, $sformatf("u%0d_send_timeout", d), 320'(r_out[d]), 320'd1);
            return;
        end
        if (d == 0) exp_q0.push_back({ee, 32'(cyc + 1 + lat), es});
        else        exp_q1.push_back({ee, 32'(cyc + 1 + lat), es});
        s_in[d] = s;
        r_in[d] = nr;
        v_in[d] = 1'b1;
        @(posedge clk); #1;
        for (int h = 0; h < hold; h++) begin
            s_in[d] = rand320();
            r_in[d] = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
        end
        v_in[d] = 1'b0;
        s_in[d] = rand320();
        r_in[d] = 4'($urandom_range(0, 15));
    endtask

    task automatic send(input int d, input logic [319:0] s, input logic [3:0] nr, input int hold);
        int n;
        int u;
        int lat;
        bit ee;
        u  = (d == 0) ? 1 : 4;
        n  = int'(nr);
        ee = 1'b0;
        if (nr > 4'd12) begin
`ifdef ASCON_PERM_ERR_EN
            n  = 0;
            ee = 1'b1;
`else
            n  = 12;
`endif
        end
        lat = (n == 0) ? 1 : (n + u - 1) / u;
        issue(d, s, nr, (ee ? s : model(s, n)), ee, lat, hold);
    endtask

    task automatic wait_idle(input int d);
        int guard = 0;
        while (((d == 0) ? exp_q0.size() : exp_q1.size()) != 0 || bsy[d]) begin
            if (guard >= 300) break;
            @(posedge clk); #1;
            guard++;
        end
        chk(((d == 0) ? exp_q0.size() : exp_q1.size()) == 0 && !bsy[d],
            $sformatf("u%0d_drain", d), 320'(bsy[d]), 320'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    task automatic monitor_step(input int d);
        logic [W-1:0] e;
        bit have;
        if (!rst) begin
            prev_v[d]  = 1'b0;
            prev_hs[d] = 1'b0;
            return;
        end
        if (prev_hs[d]) begin
            chk(!v_out[d] && r_out[d] && !bsy[d], $sformatf("u%0d_idle_after_hs", d),
                320'({v_out[d], r_out[d], bsy[d]}), 320'(3'b010));
        end else if (prev_v[d]) begin
            chk(v_out[d] && s_out[d] == prev_s[d], $sformatf("u%0d_hold_stable", d),
                s_out[d], prev_s[d]);
            chk(!r_out[d] && bsy[d], $sformatf("u%0d_done_flags", d),
                320'({r_out[d], bsy[d]}), 320'(2'b01));
        end
        if (v_out[d] && !prev_v[d]) rise[d] = cyc;
        if (v_out[d] && rdy[d]) begin
            have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
            if (!have) begin
                chk(1'b0, $sformatf("u%0d_unexpected_out", d), s_out[d], 320'd0);
            end else begin
                if (d == 0) e = exp_q0.pop_front();
                else        e = exp_q1.pop_front();
                chk(s_out[d] == e[319:0], $sformatf("u%0d_state", d), s_out[d], e[319:0]);
                chk(err_o[d] == e[352], $sformatf("u%0d_err", d), 320'(err_o[d]), 320'(e[352]));
                chk(32'(rise[d]) == e[351:320], $sformatf("u%0d_latency_cycle", d),
                    320'(rise[d]), 320'(e[351:320]));
            end
        end
        prev_v[d]  = v_out[d];
        prev_s[d]  = s_out[d];
        prev_hs[d] = v_out[d] && rdy[d];
    endtask

    always @(negedge clk) begin
        monitor_step(0);
        monitor_step(1);
    end

    task automatic reset_checks(input string tag);
        for (int d = 0; d < 2; d++) begin
            chk(r_out[d] && !v_out[d] && !bsy[d] && !err_o[d],
                $sformatf("u%0d_%s_flags", d, tag),
                320'({r_out[d], v_out[d], bsy[d], err_o[d]}), 320'(4'b1000));
            chk(s_out[d] == '0, $sformatf("u%0d_%s_state", d, tag), s_out[d], 320'd0);
        end
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog act=timeout exp=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            s_in[d] = '0;
            r_in[d] = '0;
            v_in[d] = 1'b0;
            rdy[d]  = 1'b1;
            prev_v[d] = 1'b0;
            prev_hs[d] = 1'b0;
            prev_s[d] = '0;
            rise[d] = 0;
        end
        #1 rst = 1'b0;
        #2 reset_checks("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // p12 of zero state, 12-cycle latency on the single-round engine
        send(0, '0, 4'd12, 0);
        wait_idle(0);

        // hand-derived single round on both engines
        issue(0, '0, 4'd1, HAND_P1, 1'b0, 1, 0);
        issue(1, '0, 4'd1, HAND_P1, 1'b0, 1, 0);
        wait_idle(0);
        wait_idle(1);

        // UNROLL=4: full, partial last cycle, and every round count
        send(1, rand320(), 4'd12, 0);
        send(1, rand320(), 4'd6, 0);
        send(1, rand320(), 4'd8, 0);
        for (int n = 0; n <= 12; n++) send(1, rand320(), 4'(n), 0);
        send(0, rand320(), 4'd5, 0);
        wait_idle(0);
        wait_idle(1);

        // backpressure held in DONE
        rdy[1] = 1'b0;
        send(1, rand320(), 4'd6, 0);
        repeat (22) @(posedge clk);
        #1;
        chk(v_out[1] && !r_out[1] && bsy[1], "u1_backpressure_flags",
            320'({v_out[1], r_out[1], bsy[1]}), 320'(3'b101));
        rdy[1] = 1'b1;
        wait_idle(1);

        // async reset in the middle of a 12-round job, then a fresh job
        send(0, rand320(), 4'd12, 0);
        repeat (4) @(posedge clk);
        #2 rst = 1'b0;
        #1 reset_checks("midrun_reset");
        exp_q0.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        send(0, rand320(), 4'd12, 0);
        wait_idle(0);

        // zero rounds and out-of-range round counts
        send(0, rand320(), 4'd0, 0);
        send(1, rand320(), 4'd0, 0);
        send(1, rand320(), 4'd15, 0);
        send(0, rand320(), 4'd13, 0);
        wait_idle(0);
        wait_idle(1);

        // valid_in held with changing data while running
        send(1, rand320(), 4'd12, 2);
        send(0, rand320(), 4'd3, 1);
        wait_idle(0);
        wait_idle(1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
